state_history_logger: RTL
=========================

Name: state_history_logger

Overview:
- Parametrised debug logger for power-sequencing state machines; successor to the fixed 4-deep state logger.
- Records each change of a monitored state bus into a DEPTH-entry circular history, with a saturating dwell-time stamp per entry.
- Supports trigger-and-freeze capture with programmable post-trigger depth, and indexed register-style readout for the management interface.

Parameters:
- WIDTH, 8, width of monitored state bus.
- DEPTH, 8, number of history entries; power of two, >= 2.
- TS_WIDTH, 16, width of the dwell-time field.
- POST_TRIG, 2, changes still logged after a trigger before freezing; 0..DEPTH-1.
- IDX_W, $clog2(DEPTH), readout index width.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iClear_n  in  1  synchronous active-low clear; priority over all other inputs.
- iEnable  in  1  logging enable; changes are ignored while low.
- iTick  in  1  dwell-time timebase strobe.
- iTrig  in  1  capture trigger, level sampled every cycle.
- iDbgSt  in  WIDTH  monitored state.
- iRdIdx  in  IDX_W  readout index; 0 = newest entry.
- oRdState  out  WIDTH  state field of the indexed entry.
- oRdDwell  out  TS_WIDTH  dwell field of the indexed entry.
- oRdValid  out  1  indexed entry holds data.
- oCurState  out  WIDTH  last logged state.
- oCount  out  IDX_W+1  number of valid entries, saturating at DEPTH.
- oChange  out  1  one-cycle pulse per logged change.
- oAnyChange  out  1  sticky; set by the first logged change.
- oFrozen  out  1  capture frozen.

Behaviour:
- Reset (iRst_n low): all outputs, entries, pointers, dwell counter and post counter are 0; FSM goes to ARMED.
- Change event: iEnable=1 and iDbgSt != oCurState, with the FSM not in FROZEN.
- On a change event, in the same clock edge:
  - the entry at the write pointer gets {state = iDbgSt, dwell = current dwell counter};
  - the write pointer increments mod DEPTH (wraps, overwriting the oldest entry);
  - oCount increments, saturating at DEPTH;
  - oCurState <= iDbgSt; oChange = 1 for one cycle; oAnyChange <= 1;
  - the dwell counter is set to 0.
- Dwell counter:
  - increments on each iTick in cycles with no change event; saturates at all-ones.
  - A change and an iTick in the same cycle: the counter is set to 0; that tick is not counted.
- The first change from reset compares against oCurState=0; iDbgSt=0 after reset is not logged.
- FSM states:
  - ARMED: logs changes. iTrig=1 with POST_TRIG=0 -> FROZEN. iTrig=1 with POST_TRIG>0 -> POST, post counter = POST_TRIG.
  - POST: logs changes; each logged change decrements the post counter. The change that brings it to 0 is logged, and the FSM enters FROZEN on that same edge. iTrig is ignored.
  - FROZEN: no logging; dwell counter holds; oFrozen=1; exit only via iClear_n or reset.
- Change and iTrig in the same ARMED cycle: the change is logged and does not count toward POST_TRIG.
- iClear_n low: same effect as reset on the next edge (FSM -> ARMED, all state cleared). A change or trigger in that cycle is discarded.
- Readout:
  - registered, 1-cycle latency from iRdIdx to oRd*.
  - Entry address = (write pointer - 1 - iRdIdx) mod DEPTH.
  - iRdIdx >= oCount: oRdValid=0, oRdState=0, oRdDwell=0.
  - Readout is allowed in any FSM state and never disturbs logging.
  - A read of index 0 in a cycle where a change is logged returns the pre-change newest entry.
- iEnable low: no changes are logged, the dwell counter keeps counting, and iTrig still acts.

Test Plan:
- Reset, then iDbgSt 0->3->5->9 with 4 iTicks between each change -> oCount=3; idx0={9,4}, idx1={5,4}, idx2={3,4} (first dwell counted from reset); oChange pulses 3 times; oAnyChange=1.
- DEPTH=8, 10 distinct changes -> oCount=8; idx7 = 3rd change; idx0 = 10th change; iRdIdx beyond oCount never occurs; the pointer wraps cleanly.
- POST_TRIG=2: iTrig, then changes to A,B,C -> A and B logged, oFrozen=1 on the B edge, C ignored, oCurState=B.
- POST_TRIG=0: iTrig and a change in the same cycle -> the change is logged, oFrozen=1 next cycle; later changes are ignored.
- Dwell saturation: TS_WIDTH=4, 20 iTicks then a change -> entry dwell = 15.
- iClear_n low in POST concurrent with a change -> next cycle oCount=0, oFrozen=0, oCurState=0, oChange=0; an asynchronous iRst_n pulse mid-stream likewise clears everything immediately.

Source files
------------

// File: rtl/state_history_logger.sv
// state_history_logger
// Records each change of a monitored state bus into a circular history with a
// saturating dwell stamp per entry. A trigger arms a post-trigger window after
// which logging freezes until cleared. Entries are read back by age index.
//
// Read port contract: iRdIdx is sampled on every clock edge. oRdValid/oRdState/
// oRdDwell describe that index one cycle later. They reflect the history as it
// stood before the edge, so a read that coincides with a logged change returns
// the pre-change entry.
module state_history_logger #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int TS_WIDTH  = 16,
   parameter int POST_TRIG = 2,
   parameter int IDX_W     = $clog2(DEPTH)
) (
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic                iClear_n,
   input  logic                iEnable,
   input  logic                iTick,
   input  logic                iTrig,
   input  logic [WIDTH-1:0]    iDbgSt,
   input  logic [IDX_W-1:0]    iRdIdx,
   output logic [WIDTH-1:0]    oRdState,
   output logic [TS_WIDTH-1:0] oRdDwell,
   output logic                oRdValid,
   output logic [WIDTH-1:0]    oCurState,
   output logic [IDX_W:0]      oCount,
   output logic                oChange,
   output logic                oAnyChange,
   output logic                oFrozen,
   output logic [1:0]          oFsmSt
);

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_POST   = 2'd1,
      ST_FROZEN = 2'd2
   } fsm_t;

   localparam logic [IDX_W:0]   LP_POST  = POST_TRIG[IDX_W:0];
   localparam logic [IDX_W:0]   LP_DEPTH = DEPTH[IDX_W:0];
   localparam logic [IDX_W:0]   LP_ONE   = {{IDX_W{1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] LP_IONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   fsm_t                r_state;
   fsm_t                w_next;
   logic                w_frozen;
   logic                w_change;

   logic [WIDTH-1:0]    r_mem_st [DEPTH];
   logic [TS_WIDTH-1:0] r_mem_dw [DEPTH];
   logic [IDX_W-1:0]    r_wr_ptr;
   logic [IDX_W:0]      r_count;
   logic [WIDTH-1:0]    r_cur;
   logic                r_chg;
   logic                r_any;
   logic [TS_WIDTH-1:0] r_dwell;
   logic [IDX_W:0]      r_post_cnt;

   logic [IDX_W-1:0]    w_rd_addr;
   logic                w_rd_hit;
   logic [WIDTH-1:0]    r_rd_st;
   logic [TS_WIDTH-1:0] r_rd_dw;
   logic                r_rd_v;

   // FSM state register; clear returns to ARMED like reset
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)        r_state <= ST_ARMED;
      else if (!iClear_n) r_state <= ST_ARMED;
      else                r_state <= w_next;
   end

   // Next state: trigger arms the post window, last post change freezes
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_ARMED:  if (iTrig) w_next = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
         ST_POST:   if (w_change && (r_post_cnt == LP_ONE)) w_next = ST_FROZEN;
         ST_FROZEN: w_next = ST_FROZEN;
         default:   w_next = ST_ARMED;
      endcase
   end

   // FSM outputs: frozen flag and the qualified change event
   always_comb begin
      w_frozen = (r_state == ST_FROZEN);
      w_change = iEnable && (iDbgSt != r_cur) && !w_frozen;
   end

   // Pointers, counters, current state and dwell timer
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n || !iClear_n) begin
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_cur      <= '0;
         r_chg      <= 1'b0;
         r_any      <= 1'b0;
         r_dwell    <= '0;
         r_post_cnt <= '0;
      end else begin
         r_chg <= w_change;
         if (w_change) begin
            r_wr_ptr <= r_wr_ptr + LP_IONE;
            if (r_count != LP_DEPTH) r_count <= r_count + LP_ONE;
            r_cur   <= iDbgSt;
            r_any   <= 1'b1;
            r_dwell <= '0;
         end else if (iTick && !w_frozen && (r_dwell != '1)) begin
            r_dwell <= r_dwell + 1'b1;
         end
         // a change in the trigger cycle is not part of the post window
         if ((r_state == ST_ARMED) && iTrig)
            r_post_cnt <= LP_POST;
         else if ((r_state == ST_POST) && w_change)
            r_post_cnt <= r_post_cnt - LP_ONE;
      end
   end

   // History storage: write the new state with the dwell it replaces
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n || !iClear_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_st[i] <= '0;
            r_mem_dw[i] <= '0;
         end
      end else if (w_change) begin
         r_mem_st[r_wr_ptr] <= iDbgSt;
         r_mem_dw[r_wr_ptr] <= r_dwell;
      end
   end

   // Read address counts back from the newest entry
   always_comb begin
      w_rd_addr = r_wr_ptr - LP_IONE - iRdIdx;
      w_rd_hit  = ({1'b0, iRdIdx} < r_count);
   end

   // Registered readout; unused slots read as zero
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n || !iClear_n) begin
         r_rd_v  <= 1'b0;
         r_rd_st <= '0;
         r_rd_dw <= '0;
      end else if (w_rd_hit) begin
         r_rd_v  <= 1'b1;
         r_rd_st <= r_mem_st[w_rd_addr];
         r_rd_dw <= r_mem_dw[w_rd_addr];
      end else begin
         r_rd_v  <= 1'b0;
         r_rd_st <= '0;
         r_rd_dw <= '0;
      end
   end

   assign oRdState   = r_rd_st;
   assign oRdDwell   = r_rd_dw;
   assign oRdValid   = r_rd_v;
   assign oCurState  = r_cur;
   assign oCount     = r_count;
   assign oChange    = r_chg;
   assign oAnyChange = r_any;
   assign oFrozen    = w_frozen;
   assign oFsmSt     = r_state;

endmodule
